// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: product codes, prices, coin decode,
// controller state encoding and the price-lookup record.
package vend_pkg;

  localparam int PRICE_W = 4;
  localparam int CODE_W  = 3;

  localparam logic [CODE_W-1:0] PROD_NONE   = 3'd0;
  localparam logic [CODE_W-1:0] PROD_CHOC   = 3'd1;
  localparam logic [CODE_W-1:0] PROD_NACHO  = 3'd2;
  localparam logic [CODE_W-1:0] PROD_COOKIE = 3'd3;
  localparam logic [CODE_W-1:0] PROD_CAN    = 3'd4;
  localparam logic [CODE_W-1:0] PROD_BOTTLE = 3'd5;

  localparam logic [PRICE_W-1:0] PRICE_CHOC   = 4'd3;
  localparam logic [PRICE_W-1:0] PRICE_NACHO  = 4'd4;
  localparam logic [PRICE_W-1:0] PRICE_COOKIE = 4'd5;
  localparam logic [PRICE_W-1:0] PRICE_CAN    = 4'd7;
  localparam logic [PRICE_W-1:0] PRICE_BOTTLE = 4'd9;

  // Controller states, kept as plain constants for the legacy encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_e;

  typedef struct packed {
    logic               valid;
    logic [PRICE_W-1:0] price;
  } price_t;

  function automatic logic [3:0] coin_units(input logic [1:0] code);
    logic [3:0] units;
    case (coin_e'(code))
      COIN_1:  units = 4'd1;
      COIN_2:  units = 4'd2;
      COIN_5:  units = 4'd5;
      default: units = 4'd10;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product-code to {valid, price} lookup; shared by the credit
// controller, the dispenser and the display logic.
module vend_price_lut
  import vend_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output price_t            info
);

  // NOTE: assigning a default before the case keeps this block purely
  // combinational; any path that skipped an assignment would infer a latch.
  always_comb begin
    info = '{valid: 1'b0, price: '0};
    case (code)
      PROD_CHOC:   info = '{valid: 1'b1, price: PRICE_CHOC};
      PROD_NACHO:  info = '{valid: 1'b1, price: PRICE_NACHO};
      PROD_COOKIE: info = '{valid: 1'b1, price: PRICE_COOKIE};
      PROD_CAN:    info = '{valid: 1'b1, price: PRICE_CAN};
      PROD_BOTTLE: info = '{valid: 1'b1, price: PRICE_BOTTLE};
      default:     info = '{valid: 1'b0, price: '0};
    endcase
  end

endmodule

// File: rtl/vend_credit_fsm.sv
// Vending front end: accumulates coin credit, validates selections, requests
// dispense (K/C), waits for the dispenser acknowledge A and returns change.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int MAX_CREDIT  = 200,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                sel_valid,
  input  logic [CODE_W-1:0]   sel_code,
  input  logic                cancel,
  input  logic                A,
  output logic                K,
  output logic [CODE_W-1:0]   C,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                sel_err,
  output logic                fault,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  if (MAX_CREDIT > (2 ** CREDIT_W) - 1 || CREDIT_W < PRICE_W || ACK_TIMEOUT < 1)
  begin : g_bad_params
    $error("vend_credit_fsm: MAX_CREDIT must fit in CREDIT_W bits and ACK_TIMEOUT must be >= 1");
  end

  logic [1:0]          state, state_d;
  logic [PRICE_W-1:0]  price_q, price_d;
  logic [TMR_W-1:0]    tmr, tmr_d, tmr_inc;
  logic [CREDIT_W-1:0] credit_d, credit_in, change_d;
  logic [CODE_W-1:0]   c_d;
  logic                k_d, change_valid_d, coin_reject_d, sel_err_d, fault_d, busy_d;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits, accepting, sel_ok;
  price_t              sel_info;

  vend_price_lut u_price_lut (
    .code (sel_code),
    .info (sel_info)
  );

  // Coin arithmetic is done one bit wider so the ceiling test cannot wrap.
  always_comb begin
    coin_sum  = {1'b0, credit} + SUM_W'(coin_units(coin_value));
    coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
    accepting = (state == ST_IDLE) || (state == ST_COLLECT);
    credit_in = (accepting && coin_valid && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit;
    // Affordability uses credit before any same-cycle coin.
    sel_ok    = sel_info.valid && (credit >= CREDIT_W'(sel_info.price));
    tmr_inc   = tmr + TMR_W'(1);
  end

  always_comb begin
    state_d        = state;
    price_d        = price_q;
    tmr_d          = tmr;
    credit_d       = credit;
    change_d       = change;
    k_d            = K;
    c_d            = C;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    sel_err_d      = 1'b0;
    fault_d        = 1'b0;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        coin_reject_d = coin_valid && !coin_fits;
        if (cancel && state == ST_COLLECT) begin
          change_d       = credit_in;
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = ST_IDLE;
        end else if (sel_valid && sel_ok) begin
          credit_d = credit_in;
          price_d  = sel_info.price;
          k_d      = 1'b1;
          c_d      = sel_code;
          tmr_d    = '0;
          state_d  = ST_VEND;
        end else begin
          sel_err_d = sel_valid;
          credit_d  = credit_in;
          state_d   = (credit_in == '0) ? ST_IDLE : ST_COLLECT;
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        if (A) begin
          k_d            = 1'b0;
          c_d            = PROD_NONE;
          change_d       = credit - CREDIT_W'(price_q);
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = ST_CHANGE;
        end else if (tmr_inc == TMR_W'(ACK_TIMEOUT)) begin
          // Dispenser never answered: refund everything, nothing was sold.
          k_d            = 1'b0;
          c_d            = PROD_NONE;
          fault_d        = 1'b1;
          change_d       = credit;
          change_valid_d = 1'b1;
          credit_d       = '0;
          state_d        = ST_CHANGE;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      default: begin
        coin_reject_d = coin_valid;
        if (!A) state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      price_q      <= '0;
      tmr          <= '0;
      credit       <= '0;
      change       <= '0;
      K            <= 1'b0;
      C            <= PROD_NONE;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      fault        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      price_q      <= price_d;
      tmr          <= tmr_d;
      credit       <= credit_d;
      change       <= change_d;
      K            <= k_d;
      C            <= c_d;
      change_valid <= change_valid_d;
      coin_reject  <= coin_reject_d;
      sel_err      <= sel_err_d;
      fault        <= fault_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Self-checking bench for vend_credit_fsm: directed scenarios plus random
// coin/select/cancel traffic against a transaction-level credit model.
module tb_vend_credit_fsm;

  localparam int CW  = 8;
  localparam int MAX = 20;
  localparam int TO  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          coin_valid;
  logic [1:0]    coin_value;
  logic          sel_valid;
  logic [2:0]    sel_code;
  logic          cancel;
  logic          A;
  logic          K;
  logic [2:0]    C;
  logic [CW-1:0] credit, change;
  logic          change_valid, coin_reject, sel_err, fault, busy;

  int checks = 0;
  int passed = 0;
  int model_credit = 0;
  bit ack_en = 1'b1;
  int price_of [8] = '{0, 3, 4, 5, 7, 9, 0, 0};
  int coin_set [4] = '{1, 2, 5, 10};

  vend_credit_fsm #(.CREDIT_W(CW), .MAX_CREDIT(MAX), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_code(sel_code), .cancel(cancel), .A(A),
    .K(K), .C(C), .credit(credit), .change(change), .change_valid(change_valid),
    .coin_reject(coin_reject), .sel_err(sel_err), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Dispenser model: registered acknowledge one cycle behind K.
  always @(posedge clk or posedge reset) begin
    if (reset) A <= 1'b0;
    else       A <= K & ack_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 1'b0; coin_value = 2'b00; sel_valid = 1'b0; sel_code = 3'd0; cancel = 1'b0;
  endtask

  function automatic logic [1:0] coin_enc(input int u);
    case (u)
      1:       return 2'b00;
      2:       return 2'b01;
      5:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic drive(input int coin_u, input int code, input bit sel, input bit can);
    coin_valid = (coin_u != 0);
    coin_value = coin_enc(coin_u);
    sel_valid  = sel;
    sel_code   = code[2:0];
    cancel     = can;
    step();
    idle_inputs();
  endtask

  task automatic do_coin(input int u);
    bit rej;
    rej = (model_credit + u > MAX);
    drive(u, 0, 1'b0, 1'b0);
    if (!rej) model_credit += u;
    checks++; if (coin_reject !== rej) $display("FAIL coin_reject: got %0b expected %0b", coin_reject, rej); else passed++;
    checks++; if (credit !== CW'(model_credit)) $display("FAIL coin_credit: got %0d expected %0d", credit, model_credit); else passed++;
  endtask

  task automatic do_cancel(input int coin_u, input bit with_sel, input int code);
    bit coin_ok, in_collect, sel_here;
    int exp_change;
    coin_ok    = (coin_u != 0) && (model_credit + coin_u <= MAX);
    in_collect = (model_credit > 0);
    sel_here   = with_sel && in_collect;
    exp_change = model_credit + (coin_ok ? coin_u : 0);
    drive(coin_u, code, sel_here, 1'b1);
    model_credit = in_collect ? 0 : exp_change;
    checks++; if (change_valid !== in_collect) $display("FAIL cancel_pulse: got %0b expected %0b", change_valid, in_collect); else passed++;
    if (in_collect) begin
      checks++; if (change !== CW'(exp_change)) $display("FAIL cancel_change: got %0d expected %0d", change, exp_change); else passed++;
    end
    checks++; if (coin_reject !== ((coin_u != 0) && !coin_ok)) $display("FAIL cancel_coin_reject: got %0b", coin_reject); else passed++;
    checks++; if (credit !== CW'(model_credit)) $display("FAIL cancel_credit: got %0d expected %0d", credit, model_credit); else passed++;
    checks++; if (K !== 1'b0 || sel_err !== 1'b0) $display("FAIL cancel_drops_sel: got K=%0b sel_err=%0b expected 0 0", K, sel_err); else passed++;
  endtask

  task automatic do_select(input int coin_u, input int code);
    int  price, newc, khigh, exp_k, exp_change;
    bit  ok, coin_ok, c_ok;
    price   = price_of[code];
    ok      = (price != 0) && (model_credit >= price);
    coin_ok = (coin_u != 0) && (model_credit + coin_u <= MAX);
    newc    = model_credit + (coin_ok ? coin_u : 0);
    drive(coin_u, code, 1'b1, 1'b0);
    model_credit = newc;
    checks++; if (sel_err !== !ok) $display("FAIL sel_err code %0d: got %0b expected %0b", code, sel_err, !ok); else passed++;
    checks++; if (K !== ok) $display("FAIL sel_K code %0d: got %0b expected %0b", code, K, ok); else passed++;
    checks++; if (coin_reject !== ((coin_u != 0) && !coin_ok)) $display("FAIL sel_coin_reject: got %0b", coin_reject); else passed++;
    checks++; if (credit !== CW'(newc)) $display("FAIL sel_credit: got %0d expected %0d", credit, newc); else passed++;
    if (ok) begin
      khigh = 0;
      c_ok  = 1'b1;
      for (int i = 0; i < 40 && K === 1'b1; i++) begin
        khigh++;
        if (C !== code[2:0]) c_ok = 1'b0;
        step();
      end
      exp_k      = ack_en ? 2 : TO;
      exp_change = ack_en ? newc - price : newc;
      checks++; if (khigh !== exp_k) $display("FAIL k_high_cycles: got %0d expected %0d", khigh, exp_k); else passed++;
      checks++; if (!c_ok) $display("FAIL c_stable: C left %0d while K=1", code); else passed++;
      checks++; if (change_valid !== 1'b1 || C !== 3'd0) $display("FAIL vend_done: got change_valid=%0b C=%0d expected 1 0", change_valid, C); else passed++;
      checks++; if (change !== CW'(exp_change)) $display("FAIL vend_change: got %0d expected %0d", change, exp_change); else passed++;
      checks++; if (fault !== !ack_en) $display("FAIL vend_fault: got %0b expected %0b", fault, !ack_en); else passed++;
      checks++; if (credit !== '0) $display("FAIL vend_credit: got %0d expected 0", credit); else passed++;
      for (int i = 0; i < 10 && busy === 1'b1; i++) step();
      checks++; if (busy !== 1'b0) $display("FAIL busy_release: got %0b expected 0", busy); else passed++;
      model_credit = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    checks++; if ({K, C, credit, change, change_valid, coin_reject, sel_err, fault, busy} !== '0)
      $display("FAIL reset_outputs: got K=%0b C=%0d credit=%0d change=%0d flags=%b expected all 0",
               K, C, credit, change, {change_valid, coin_reject, sel_err, fault, busy});
    else passed++;
    reset = 1'b0;
    step();
    checks++; if (credit !== '0 || busy !== 1'b0) $display("FAIL post_reset_idle: got credit=%0d busy=%0b", credit, busy); else passed++;
  endtask

  task automatic test_vend_exact();
    do_coin(5); do_coin(2);
    do_select(0, 4);
  endtask

  task automatic test_vend_change();
    do_coin(10);
    do_select(0, 1);
    do_coin(2);
    do_select(2, 3);
    do_cancel(0, 1'b0, 0);
  endtask

  task automatic test_sel_errors();
    do_coin(2);
    do_select(0, 3);
    do_select(0, 7);
    do_select(0, 0);
    do_select(0, 6);
    do_cancel(0, 1'b0, 0);
  endtask

  task automatic test_cancel();
    do_coin(5); do_coin(1);
    do_cancel(0, 1'b0, 0);
    do_cancel(0, 1'b0, 0);
    do_coin(5);
    do_cancel(2, 1'b1, 1);
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    do_coin(10);
    do_select(0, 2);
    ack_en = 1'b1;
  endtask

  task automatic test_coin_limits();
    do_coin(10); do_coin(5);
    do_coin(10);
    do_coin(5);
    do_coin(1);
    do_cancel(10, 1'b0, 0);
  endtask

  task automatic test_busy_and_reset();
    ack_en = 1'b0;
    do_coin(5);
    drive(0, 1, 1'b1, 1'b0);
    checks++; if (K !== 1'b1 || C !== 3'd1) $display("FAIL busy_vend_start: got K=%0b C=%0d expected 1 1", K, C); else passed++;
    drive(2, 0, 1'b0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== CW'(5)) $display("FAIL vend_coin_reject: got rej=%0b credit=%0d expected 1 5", coin_reject, credit); else passed++;
    drive(0, 3, 1'b1, 1'b1);
    checks++; if (sel_err !== 1'b0 || change_valid !== 1'b0 || K !== 1'b1) $display("FAIL vend_ignores_sel_cancel: got sel_err=%0b cv=%0b K=%0b", sel_err, change_valid, K); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (K !== 1'b0 || C !== 3'd0 || credit !== '0 || busy !== 1'b0 || change_valid !== 1'b0)
      $display("FAIL reset_mid_vend: got K=%0b C=%0d credit=%0d busy=%0b cv=%0b expected all 0", K, C, credit, busy, change_valid);
    else passed++;
    step();
    reset = 1'b0;
    ack_en = 1'b1;
    model_credit = 0;
    step();
  endtask

  task automatic test_random();
    int act, u, code;
    for (int n = 0; n < 300; n++) begin
      act  = $urandom_range(0, 9);
      u    = coin_set[$urandom_range(0, 3)];
      code = $urandom_range(0, 7);
      if (act < 5) begin
        do_coin(u);
      end else if (act < 8) begin
        ack_en = ($urandom_range(0, 7) != 0);
        do_select(($urandom_range(0, 1) != 0) ? u : 0, code);
        ack_en = 1'b1;
      end else begin
        do_cancel(($urandom_range(0, 1) != 0) ? u : 0, $urandom_range(0, 1) != 0, code);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_vend_exact();
    test_vend_change();
    test_sel_errors();
    test_cancel();
    test_timeout();
    test_coin_limits();
    test_busy_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
